// File: rtl/instr_loader.sv
// instr_loader: receives a framed byte-serial program image (A5, N lo, N hi, 4*N data, XOR)
// and writes little-endian 32-bit words to sequential instruction-memory addresses.
module instr_loader #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_wren,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W-1:0] word_count
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_WRITE,
      S_CSUM
   } state_t;

   state_t            state_q, state_d;
   logic              rx_ready_q, rx_ready_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wren_q, wren_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] wc_q, wc_d;
   logic [15:0]       n_q, n_d;
   logic [7:0]        csum_q, csum_d;
   logic [31:0]       buf_q, buf_d;
   logic [1:0]        idx_q, idx_d;
   logic [TO_W-1:0]   to_q, to_d;

   logic              accept;
   logic              last_word;
   logic              in_frame;

   assign accept    = rx_valid && rx_ready_q;
   assign last_word = (({1'b0, wc_q} + {{ADDR_W{1'b0}}, 1'b1}) == (ADDR_W + 1)'(n_q));
   assign in_frame  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wren_d  = 1'b0;
      hold_d  = hold_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wc_d    = wc_q;
      n_d     = n_q;
      csum_d  = csum_q;
      buf_d   = buf_q;
      idx_d   = idx_q;
      to_d    = '0;

      case (state_q)
         S_IDLE: begin
            if (accept && rx_data == 8'hA5) begin
               state_d = S_LEN_LO;
               hold_d  = 1'b1;
               wc_d    = '0;
               csum_d  = '0;
               idx_d   = '0;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               n_d[7:0] = rx_data;
               state_d  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               n_d[15:8] = rx_data;
               state_d   = ({rx_data, n_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               // Bytes shift in from the top so b0 ends up in bits [7:0].
               buf_d  = {rx_data, buf_q[31:8]};
               csum_d = csum_q ^ rx_data;
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_WRITE;
                  wren_d  = 1'b1;
                  addr_d  = wc_q;
                  wdata_d = {rx_data, buf_q[31:8]};
               end
            end
         end
         S_WRITE: begin
            wc_d    = wc_q + 1'b1;
            state_d = last_word ? S_CSUM : S_DATA;
         end
         S_CSUM: begin
            if (accept) begin
               done_d  = (rx_data == csum_q);
               err_d   = (rx_data != csum_q);
               hold_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Inter-byte watchdog: abort the frame after TIMEOUT consecutive idle cycles.
      if (in_frame && !accept) begin
         if (to_q == TO_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            hold_d  = 1'b0;
            state_d = S_IDLE;
         end else begin
            to_d = to_q + TO_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rx_ready_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wren_q     <= 1'b0;
         hold_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wc_q       <= '0;
         n_q        <= '0;
         csum_q     <= '0;
         buf_q      <= '0;
         idx_q      <= '0;
         to_q       <= '0;
      end else begin
         state_q    <= state_d;
         rx_ready_q <= (state_d != S_WRITE);
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wren_q     <= wren_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wc_q       <= wc_d;
         n_q        <= n_d;
         csum_q     <= csum_d;
         buf_q      <= buf_d;
         idx_q      <= idx_d;
         to_q       <= to_d;
      end
   end

   assign rx_ready   = rx_ready_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign mem_wren   = wren_q;
   assign cpu_hold   = hold_q;
   assign load_done  = done_q;
   assign load_err   = err_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed frames plus randomized frames
// compared against a frame-parsing reference model.
module tb_instr_loader;
   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 40;

   typedef logic [7:0] bq_t[$];

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [7:0]        rx_data = 8'h00;
   logic              rx_valid = 1'b0;
   logic              rx_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_wren;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W-1:0] word_count;

   instr_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wren(mem_wren), .cpu_hold(cpu_hold), .load_done(load_done),
      .load_err(load_err), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge
   logic [47:0] got_wr[$];
   int          got_wr_cyc[$];
   int          done_n = 0, err_n = 0, done_cyc = 0, err_cyc = 0;

   always @(negedge clk) begin
      if (mem_wren) begin
         got_wr.push_back({mem_addr, mem_wdata});
         got_wr_cyc.push_back(cyc);
         check("ready_low_during_write", rx_ready, 1'b0);
      end
      if (load_done) begin done_n++; done_cyc = cyc; end
      if (load_err)  begin err_n++;  err_cyc = cyc; end
   end

   task automatic clear_mon();
      got_wr.delete();
      got_wr_cyc.delete();
      done_n = 0;
      err_n  = 0;
   endtask

   // Reference model: parse one complete frame (optionally preceded by garbage)
   logic [47:0] exp_wr[$];
   int          exp_done, exp_err, exp_wc, exp_sync, exp_n;

   function automatic void model(input bq_t s);
      int i;
      logic [7:0] x;
      logic [31:0] w;
      exp_wr.delete();
      exp_done = 0; exp_err = 0; exp_wc = 0; exp_n = 0;
      i = 0;
      while (i < s.size() && s[i] != 8'hA5) i++;
      exp_sync = i;
      if (i + 2 >= s.size()) return;
      exp_n = int'(s[i+1]) + 256 * int'(s[i+2]);
      i += 3;
      x = 8'h00;
      for (int k = 0; k < exp_n; k++) begin
         w = {s[i+3], s[i+2], s[i+1], s[i]};
         x = x ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
         exp_wr.push_back({16'(k), w});
         i += 4;
      end
      exp_wc = exp_n;
      if (s[i] == x) exp_done = 1; else exp_err = 1;
   endfunction

   int acc_q[$];
   int last_acc = 0;

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      bit ok;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
      rx_data = b;
      rx_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 64; t++) begin
         if (rx_ready) begin
            ok = 1'b1;
            last_acc = cyc + 1;
            acc_q.push_back(last_acc);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      rx_valid = 1'b0;
      check("byte_accepted", ok, 1'b1);
   endtask

   task automatic send_stream(input bq_t s, input int max_gap);
      acc_q.delete();
      foreach (s[i]) send_byte(s[i], max_gap);
   endtask

   task automatic run_frame(input string tag, input bq_t s, input int max_gap, input bit timed);
      int nchk;
      clear_mon();
      model(s);
      send_stream(s, max_gap);
      repeat (4) @(negedge clk);
      check({tag, "_nwrites"}, got_wr.size(), exp_wr.size());
      nchk = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
      for (int k = 0; k < nchk; k++) begin
         check({tag, "_addr"}, got_wr[k][47:32], exp_wr[k][47:32]);
         check({tag, "_data"}, got_wr[k][31:0], exp_wr[k][31:0]);
         if (timed)
            check({tag, "_wr_cycle"}, got_wr_cyc[k] - acc_q[exp_sync], 6 + 5 * k);
      end
      check({tag, "_done"}, done_n, exp_done);
      check({tag, "_err"}, err_n, exp_err);
      check({tag, "_word_count"}, word_count, exp_wc);
      check({tag, "_hold_released"}, cpu_hold, 1'b0);
      if (timed && exp_done == 1)
         check({tag, "_frame_cycles"}, done_cyc - acc_q[exp_sync], 3 + 5 * exp_n);
      $display("frame %s: N=%0d writes=%0d done=%0d err=%0d word_count=%0d",
               tag, exp_n, got_wr.size(), done_n, err_n, word_count);
   endtask

   initial begin
      bq_t s;
      int  a;

      // Reset held for two cycles
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_rx_ready", rx_ready, 1'b0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_wren", mem_wren, 1'b0);
      check("rst_cpu_hold", cpu_hold, 1'b0);
      check("rst_load_done", load_done, 1'b0);
      check("rst_load_err", load_err, 1'b0);
      check("rst_word_count", word_count, 0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_rx_ready", rx_ready, 1'b1);
      $display("reset: rx_ready=%0b cpu_hold=%0b", rx_ready, cpu_hold);

      s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      run_frame("good2", s, 0, 1'b1);

      s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h00};
      run_frame("badcs", s, 0, 1'b1);

      s = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
      run_frame("n0_garbage", s, 0, 1'b1);

      // Inter-byte timeout
      clear_mon();
      s = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
      send_stream(s, 0);
      a = last_acc;
      check("to_hold_in_frame", cpu_hold, 1'b1);
      for (int t = 0; t < TIMEOUT + 10 && err_n == 0; t++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("to_err_pulses", err_n, 1);
      check("to_err_cycle", err_cyc - a, TIMEOUT);
      check("to_no_write", got_wr.size(), 0);
      check("to_no_done", done_n, 0);
      check("to_hold_released", cpu_hold, 1'b0);
      check("to_rx_ready", rx_ready, 1'b1);
      $display("frame timeout: err=%0d after %0d idle cycles", err_n, err_cyc - a);

      s = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
            8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
      run_frame("after_timeout", s, 2, 1'b0);

      // Reset in the middle of a throttled frame
      clear_mon();
      s = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5};
      send_stream(s, 3);
      check("mid_hold_before_reset", cpu_hold, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_hold", cpu_hold, 1'b0);
      check("mid_rst_word_count", word_count, 0);
      check("mid_rst_rx_ready", rx_ready, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_after", rx_ready, 1'b1);
      repeat (3) @(negedge clk);
      check("mid_rst_no_done", done_n, 0);
      check("mid_rst_no_err", err_n, 0);
      check("mid_rst_no_write", got_wr.size(), 0);
      $display("frame mid_reset: cpu_hold=%0b done=%0d err=%0d", cpu_hold, done_n, err_n);

      s = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
      run_frame("a5_data", s, 3, 1'b0);

      // Randomized frames with garbage prefix, embedded A5 and throttled source
      for (int f = 0; f < 10; f++) begin
         int n, pre;
         logic [7:0] x, b;
         s.delete();
         pre = $urandom_range(3, 0);
         repeat (pre) begin
            b = 8'($urandom_range(255, 0));
            if (b == 8'hA5) b = 8'h5A;
            s.push_back(b);
         end
         n = $urandom_range(5, 1);
         s.push_back(8'hA5);
         s.push_back(8'(n));
         s.push_back(8'(n >> 8));
         x = 8'h00;
         for (int k = 0; k < 4 * n; k++) begin
            b = ($urandom_range(3, 0) == 0) ? 8'hA5 : 8'($urandom_range(255, 0));
            x = x ^ b;
            s.push_back(b);
         end
         if ($urandom_range(1, 0) == 1) s.push_back(x);
         else s.push_back(x ^ 8'($urandom_range(255, 1)));
         run_frame($sformatf("rand%0d", f), s, (f % 2 == 0) ? 0 : 3, (f % 2 == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader for the pipelined CPU: it sits on the write side of the instruction memory that `instr_fetch` reads. It accepts a framed, byte-serial program image from a byte source (UART receiver) over a valid/ready handshake. It assembles little-endian 32-bit words and writes them to sequential instruction-memory addresses. It holds the CPU while a load is in progress and reports success or failure.

## Interface
Parameters:
- `ADDR_W`, 16, instruction-memory address width (matches 16-bit PC).
- `TIMEOUT`, 100000, max idle cycles between bytes inside a frame before abort.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte this cycle.
- `mem_addr`  out  ADDR_W  instruction-memory write address.
- `mem_wdata`  out  32  instruction word to write.
- `mem_wren`  out  1  write strobe, one cycle per word.
- `cpu_hold`  out  1  held high during a load; drives CPU stall/reset.
- `load_done`  out  1  one-cycle pulse: frame written and checksum good.
- `load_err`  out  1  one-cycle pulse: checksum mismatch or timeout.
- `word_count`  out  ADDR_W  words written in current/last frame.

## Operation
- Byte accepted on any cycle with `rx_valid && rx_ready`; only accepted bytes advance state.
- Frame format: sync `0xA5`, `N[7:0]`, `N[15:8]`, then 4·N data bytes (word k = bytes b0..b3, `mem_wdata = {b3,b2,b1,b0}`), then checksum byte = XOR of all 4·N data bytes (sync/length excluded).
- States:
  - IDLE: non-`0xA5` bytes are accepted and discarded. `0xA5` goes to LEN_LO, sets `cpu_hold`, and clears `word_count`, checksum and byte index.
  - LEN_LO: store N low, go to LEN_HI.
  - LEN_HI: store N high. If N==0, go to CSUM. Else go to DATA.
  - DATA: shift byte into word buffer and XOR into checksum. On 4th byte go to WRITE.
  - WRITE (1 cycle): `mem_wren`=1, `mem_addr`=`word_count`, `mem_wdata`=buffer; increment `word_count`. If `word_count`+1==N, go to CSUM. Else go to DATA.
  - CSUM: compare byte to running XOR. Equal gives `load_done`, else `load_err`. Go to IDLE and drop `cpu_hold`.
- Timeout: in LEN_LO/LEN_HI/DATA/CSUM, a counter resets on each accepted byte. Reaching TIMEOUT gives `load_err`, go to IDLE, drop `cpu_hold`. Words already written stay written.
- A `0xA5` inside a frame is ordinary data, not a resync.
- Address is word index from 0. Max N=65535 means last address 0xFFFE, so no wrap.
- `word_count` holds its final value in IDLE until the next sync byte.

## Timing
- Reset values: `rx_ready`=0 during reset then 1 in IDLE; `mem_addr`=0, `mem_wdata`=0, `mem_wren`=0, `cpu_hold`=0, `load_done`=0, `load_err`=0, `word_count`=0; state IDLE.
- `rx_ready`=1 in IDLE, LEN_LO, LEN_HI, DATA, CSUM; 0 in WRITE and during reset.
- All outputs are registered.
- `mem_wren` is high exactly the cycle after the 4th byte of a word is accepted. Address and data are stable that cycle.
- `cpu_hold` rises the cycle after sync is accepted. It falls the cycle after the checksum byte is accepted (coincident with `load_done`/`load_err`) or on timeout.
- Minimum frame duration is 3 + 5·N + 1 cycles with back-to-back bytes.
- `reset` mid-frame returns to IDLE next cycle with all outputs at reset values. There is no done/err pulse; partial writes are not undone.

## Test plan
- Reset: hold `reset` 2 cycles -> all outputs 0, `rx_ready`=1 after release.
- Good 2-word frame, back-to-back: A5 02 00 11 22 33 44 55 66 77 88 CS=0x88 -> writes 0x44332211@0 and 0x88776655@1 (one `mem_wren` cycle each), then `load_done` pulse, `word_count`=2, `cpu_hold` low.
- Bad checksum: same frame with CS=0x00 -> both writes occur, `load_err` pulse, no `load_done`.
- N=0 and garbage prefix: 00 FF A5 00 00 00 -> garbage ignored, no `mem_wren`, `load_done`.
- Timeout: A5 01 00 11 22, then `rx_valid`=0 for TIMEOUT cycles -> `load_err`, IDLE, no write; a following good frame loads normally.
- Throttled source with `0xA5` in data and reset mid-frame: random `rx_valid` gaps, word bytes A5 A5 A5 A5 -> word 0xA5A5A5A5 written. Asserting `reset` after the 2nd data byte -> IDLE, `cpu_hold`=0, no pulse.
